// File: rtl/power_seq_ctrl.sv
// Power-on/off sequencer: brings up the PFC stage, then the DC-DC stage, from the filtered
// front-panel switch, tears down in reverse order, and retries faults up to a lockout limit.
module power_seq_ctrl #(
  parameter int CNT_W      = 20,
  parameter int PFC_DLY    = 1000,
  parameter int PFC_TMO    = 500000,
  parameter int DCDC_DLY   = 2000,
  parameter int OFF_DLY    = 1000,
  parameter int RETRY_WAIT = 100000,
  parameter int RETRY_MAX  = 3
) (
  input  logic       clk_in,
  input  logic       rst_i,
  input  logic       sw_state_i,
  input  logic       pfc_ok_i,
  input  logic       fault_i,
  output logic       pfc_en_o,
  output logic       dcdc_en_o,
  output logic       run_o,
  output logic       lockout_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PFC_START  = 3'd1,
    PFC_WAIT   = 3'd2,
    DCDC_START = 3'd3,
    RUN        = 3'd4,
    SHUTDOWN   = 3'd5,
    FAULT      = 3'd6,
    LOCKOUT    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PFC_DLY_LAST    = CNT_W'(PFC_DLY - 1);
  localparam logic [CNT_W-1:0] PFC_TMO_LAST    = CNT_W'(PFC_TMO - 1);
  localparam logic [CNT_W-1:0] DCDC_DLY_LAST   = CNT_W'(DCDC_DLY - 1);
  localparam logic [CNT_W-1:0] OFF_DLY_LAST    = CNT_W'(OFF_DLY - 1);
  localparam logic [CNT_W-1:0] RETRY_WAIT_LAST = CNT_W'(RETRY_WAIT - 1);
  localparam logic [2:0]       RETRY_LIMIT     = 3'(RETRY_MAX);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt, cnt_limit;
  logic [2:0]       retry_cnt, next_retry, retry_inc;
  logic             cnt_done;

  // Timed states leave on their last counted cycle; untimed states keep the counter parked at 0.
  always_comb begin
    cnt_limit = '0;
    case (state)
      PFC_START:  cnt_limit = PFC_DLY_LAST;
      PFC_WAIT:   cnt_limit = PFC_TMO_LAST;
      DCDC_START: cnt_limit = DCDC_DLY_LAST;
      SHUTDOWN:   cnt_limit = OFF_DLY_LAST;
      FAULT:      cnt_limit = RETRY_WAIT_LAST;
      default:    cnt_limit = '0;
    endcase
  end

  assign cnt_done  = (cnt == cnt_limit);
  assign retry_inc = (retry_cnt >= RETRY_LIMIT) ? RETRY_LIMIT : retry_cnt + 3'd1;

  always_comb begin
    next_state = state;
    next_retry = retry_cnt;
    case (state)
      IDLE: begin
        if (sw_state_i) next_state = PFC_START;
        else            next_retry = '0;
      end
      PFC_START: begin
        if (!sw_state_i)   next_state = IDLE;
        else if (cnt_done) next_state = PFC_WAIT;
      end
      PFC_WAIT: begin
        if (pfc_ok_i)         next_state = DCDC_START;
        else if (!sw_state_i) next_state = SHUTDOWN;
        else if (cnt_done)    next_state = FAULT;
      end
      DCDC_START: begin
        if (!pfc_ok_i)        next_state = FAULT;
        else if (!sw_state_i) next_state = SHUTDOWN;
        else if (cnt_done)    next_state = RUN;
      end
      RUN: begin
        if (!pfc_ok_i)        next_state = FAULT;
        else if (!sw_state_i) next_state = SHUTDOWN;
      end
      SHUTDOWN: begin
        if (cnt_done) next_state = IDLE;
      end
      FAULT: begin
        if (cnt_done && !fault_i) next_state = IDLE;
      end
      LOCKOUT: begin
        if (!sw_state_i && !fault_i) begin
          next_state = IDLE;
          next_retry = '0;
        end
      end
    endcase

    // A hard fault pre-empts every active state, even a same-cycle switch-off or timeout.
    if (fault_i && (state != FAULT) && (state != LOCKOUT))
      next_state = FAULT;

    if ((next_state == FAULT) && (state != FAULT)) begin
      next_retry = retry_inc;
      if (retry_inc == RETRY_LIMIT) next_state = LOCKOUT;
    end

    next_cnt = (next_state != state) ? '0 : (cnt_done ? cnt : cnt + CNT_W'(1));
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk_in) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      retry_cnt <= '0;
      pfc_en_o  <= 1'b0;
      dcdc_en_o <= 1'b0;
      run_o     <= 1'b0;
      lockout_o <= 1'b0;
      state_o   <= 3'd0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      retry_cnt <= next_retry;
      pfc_en_o  <= (next_state == PFC_WAIT) || (next_state == DCDC_START) ||
                   (next_state == RUN) || (next_state == SHUTDOWN);
      dcdc_en_o <= (next_state == RUN);
      run_o     <= (next_state == RUN);
      lockout_o <= (next_state == LOCKOUT);
      state_o   <= next_state;
    end
  end

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Bench for power_seq_ctrl: directed sequencing scenarios followed by a random run, every
// cycle compared against a reference built from the sequencing rules with elapsed-cycle counts.
module tb_power_seq_ctrl;

  localparam int PFC_DLY    = 4;
  localparam int PFC_TMO    = 20;
  localparam int DCDC_DLY   = 8;
  localparam int OFF_DLY    = 5;
  localparam int RETRY_WAIT = 10;
  localparam int RETRY_MAX  = 3;

  logic       clk_in = 1'b0;
  logic       rst_i = 1'b1;
  logic       sw_state_i = 1'b0;
  logic       pfc_ok_i = 1'b0;
  logic       fault_i = 1'b0;
  logic       pfc_en_o, dcdc_en_o, run_o, lockout_o;
  logic [2:0] state_o;

  int m_st = 0;
  int m_age = 0;
  int m_retry = 0;
  int nChecks = 0;
  int nFail = 0;
  logic rSw, rOk, rFlt, rRst;

  power_seq_ctrl #(
    .CNT_W(20), .PFC_DLY(PFC_DLY), .PFC_TMO(PFC_TMO), .DCDC_DLY(DCDC_DLY),
    .OFF_DLY(OFF_DLY), .RETRY_WAIT(RETRY_WAIT), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk_in(clk_in), .rst_i(rst_i), .sw_state_i(sw_state_i), .pfc_ok_i(pfc_ok_i),
    .fault_i(fault_i), .pfc_en_o(pfc_en_o), .dcdc_en_o(dcdc_en_o), .run_o(run_o),
    .lockout_o(lockout_o), .state_o(state_o)
  );

  always #5 clk_in = ~clk_in;

  // Reference: phase number plus cycles already spent there; a delay of N ends on cycle N.
  task automatic modelStep(input logic sw, input logic ok, input logic flt, input logic rst);
    int nxt;
    if (rst) begin
      m_st = 0; m_age = 0; m_retry = 0;
      return;
    end
    nxt = m_st;
    if (flt && m_st <= 5) nxt = 6;
    else begin
      case (m_st)
        0: if (sw) nxt = 1; else m_retry = 0;
        1: if (!sw) nxt = 0; else if (m_age + 1 >= PFC_DLY) nxt = 2;
        2: if (ok) nxt = 3; else if (!sw) nxt = 5; else if (m_age + 1 >= PFC_TMO) nxt = 6;
        3: if (!ok) nxt = 6; else if (!sw) nxt = 5; else if (m_age + 1 >= DCDC_DLY) nxt = 4;
        4: if (!ok) nxt = 6; else if (!sw) nxt = 5;
        5: if (m_age + 1 >= OFF_DLY) nxt = 0;
        6: if (m_age + 1 >= RETRY_WAIT && !flt) nxt = 0;
        default: if (!sw && !flt) begin nxt = 0; m_retry = 0; end
      endcase
    end
    if (nxt == 6 && m_st != 6) begin
      m_retry = (m_retry + 1 > RETRY_MAX) ? RETRY_MAX : m_retry + 1;
      if (m_retry == RETRY_MAX) nxt = 7;
    end
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  task automatic checkVal(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pfc_en"},  {2'b00, pfc_en_o},  3'(m_st >= 2 && m_st <= 5));
    checkVal({tag, ".dcdc_en"}, {2'b00, dcdc_en_o}, 3'(m_st == 4));
    checkVal({tag, ".run"},     {2'b00, run_o},     3'(m_st == 4));
    checkVal({tag, ".lockout"}, {2'b00, lockout_o}, 3'(m_st == 7));
    checkVal({tag, ".state"},   state_o,            3'(m_st));
  endtask

  task automatic applyStimulus(input logic sw, input logic ok, input logic flt, input logic rst);
    sw_state_i = sw;
    pfc_ok_i   = ok;
    fault_i    = flt;
    rst_i      = rst;
    @(posedge clk_in);
    modelStep(sw, ok, flt, rst);
    #1;
    checkOutput("model");
  endtask

  task automatic runCycles(input int n, input logic sw, input logic ok, input logic flt);
    for (int i = 0; i < n; i++) applyStimulus(sw, ok, flt, 1'b0);
  endtask

  // Starts from IDLE: switch on at edge 0, bus good from edge 10, RUN after edge 18.
  task automatic normalStart(input string tag);
    runCycles(4, 1'b1, 1'b0, 1'b0);
    checkVal({tag, "_pfc_edge3"}, {2'b00, pfc_en_o}, 3'd0);
    checkVal({tag, "_state_edge3"}, state_o, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal({tag, "_pfc_edge4"}, {2'b00, pfc_en_o}, 3'd1);
    runCycles(5, 1'b1, 1'b0, 1'b0);
    runCycles(8, 1'b1, 1'b1, 1'b0);
    checkVal({tag, "_dcdc_edge17"}, {2'b00, dcdc_en_o}, 3'd0);
    checkVal({tag, "_state_edge17"}, state_o, 3'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkVal({tag, "_dcdc_edge18"}, {2'b00, dcdc_en_o}, 3'd1);
    checkVal({tag, "_run_edge18"}, {2'b00, run_o}, 3'd1);
    checkVal({tag, "_state_edge18"}, state_o, 3'd4);
  endtask

  initial begin
    $display("[TB] power_seq_ctrl bench starting");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("reset_state", state_o, 3'd0);
    checkVal("reset_pfc", {2'b00, pfc_en_o}, 3'd0);
    checkVal("reset_lockout", {2'b00, lockout_o}, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    normalStart("s1");

    // Normal stop: DC-DC drops at once, PFC follows OFF_DLY edges later.
    runCycles(3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("s2_dcdc_T", {2'b00, dcdc_en_o}, 3'd0);
    checkVal("s2_run_T", {2'b00, run_o}, 3'd0);
    checkVal("s2_pfc_T", {2'b00, pfc_en_o}, 3'd1);
    checkVal("s2_state_T", state_o, 3'd5);
    runCycles(4, 1'b0, 1'b1, 1'b0);
    checkVal("s2_pfc_T4", {2'b00, pfc_en_o}, 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("s2_pfc_T5", {2'b00, pfc_en_o}, 3'd0);
    checkVal("s2_state_T5", state_o, 3'd0);

    // Bus timeout, fault wait, then automatic re-arm.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(5, 1'b1, 1'b0, 1'b0);
    checkVal("s3_pfc_edge4", {2'b00, pfc_en_o}, 3'd1);
    runCycles(19, 1'b1, 1'b0, 1'b0);
    checkVal("s3_pfc_edge23", {2'b00, pfc_en_o}, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("s3_state_edge24", state_o, 3'd6);
    checkVal("s3_pfc_edge24", {2'b00, pfc_en_o}, 3'd0);
    runCycles(9, 1'b1, 1'b0, 1'b0);
    checkVal("s3_state_edge33", state_o, 3'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("s3_state_edge34", state_o, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("s3_state_edge35", state_o, 3'd1);

    // Two further timeouts reach lockout, which survives switch-on and an active fault.
    runCycles(58, 1'b1, 1'b0, 1'b0);
    checkVal("s4_state_before", state_o, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("s4_state_lock", state_o, 3'd7);
    checkVal("s4_lockout", {2'b00, lockout_o}, 3'd1);
    runCycles(20, 1'b1, 1'b0, 1'b0);
    checkVal("s4_lock_hold", state_o, 3'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("s4_lock_fault_hold", state_o, 3'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("s4_lock_exit", state_o, 3'd0);
    checkVal("s4_lockout_clear", {2'b00, lockout_o}, 3'd0);
    normalStart("s4");

    // Fault and switch-off on the same edge in RUN: fault wins, and holds while fault_i stays high.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("s5_fault_state", state_o, 3'd6);
    checkVal("s5_fault_pfc", {2'b00, pfc_en_o}, 3'd0);
    checkVal("s5_fault_dcdc", {2'b00, dcdc_en_o}, 3'd0);
    runCycles(12, 1'b0, 1'b1, 1'b1);
    checkVal("s5_fault_hold", state_o, 3'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("s5_fault_exit", state_o, 3'd0);

    // Bus-good arriving on the timeout cycle wins over the timeout.
    runCycles(24, 1'b1, 1'b0, 1'b0);
    checkVal("s5_wait_state", state_o, 3'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("s5_ok_on_timeout", state_o, 3'd3);
    runCycles(8, 1'b1, 1'b1, 1'b0);
    checkVal("s5_run_after", state_o, 3'd4);

    // Second fault leaves the retry count at 2 before a mid-RUN reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("s6_second_fault", state_o, 3'd6);
    runCycles(10, 1'b1, 1'b1, 1'b0);
    checkVal("s6_rearm_idle", state_o, 3'd0);
    normalStart("s6a");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("s6_reset_state", state_o, 3'd0);
    checkVal("s6_reset_pfc", {2'b00, pfc_en_o}, 3'd0);
    checkVal("s6_reset_dcdc", {2'b00, dcdc_en_o}, 3'd0);
    checkVal("s6_reset_run", {2'b00, run_o}, 3'd0);
    normalStart("s6b");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("s6_retry_cleared", state_o, 3'd6);

    // Random run against the reference.
    rSw = 1'b1; rOk = 1'b0; rFlt = 1'b0; rRst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) rSw = ~rSw;
      if ($urandom_range(0, 24) == 0) rOk = ~rOk;
      rFlt = ($urandom_range(0, 99) < 2);
      rRst = ($urandom_range(0, 599) == 0);
      applyStimulus(rSw, rOk, rFlt, rRst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/power_seq_ctrl.md
# power_seq_ctrl

Power-on/off sequencer that consumes the debounced front-panel switch state from the switch signal checker and drives the rectifier's PFC and DC-DC enables in a fixed order. It sits directly downstream of the switch checker. It waits for PFC bus-good before enabling the DC-DC, and shuts down in reverse order. Startup or run faults trigger timed retries, with a lockout after a configurable number of consecutive failures.

## Interface
- CNT_W, 20: width of the shared delay counter.
- PFC_DLY, 1000: cycles from accepted on-request to pfc_en_o high (pre-charge settle).
- PFC_TMO, 500000: max cycles in PFC_WAIT for pfc_ok_i before fault.
- DCDC_DLY, 2000: cycles pfc_ok_i must stay high before dcdc_en_o.
- OFF_DLY, 1000: cycles PFC stays enabled after dcdc_en_o drops on shutdown.
- RETRY_WAIT, 100000: cycles spent in FAULT before re-arming.
- RETRY_MAX, 3: consecutive faults that force LOCKOUT (1..7).
- All delay parameters ≥1 and < 2^CNT_W.

Ports:
- clk_in  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- sw_state_i  in  1  filtered switch state from the checker; 1 = on request.
- pfc_ok_i  in  1  PFC bus-voltage-good, already synchronous to clk_in.
- fault_i  in  1  aggregated hard fault (OVP/OCP/OTP), synchronous level.
- pfc_en_o  out  1  PFC stage enable.
- dcdc_en_o  out  1  DC-DC stage enable.
- run_o  out  1  high only in RUN.
- lockout_o  out  1  high only in LOCKOUT.
- state_o  out  3  current state code.

## Operation
- States and codes: IDLE=0, PFC_START=1, PFC_WAIT=2, DCDC_START=3, RUN=4, SHUTDOWN=5, FAULT=6, LOCKOUT=7.
- The delay counter clears on every state entry. An N-cycle delay spends exactly N cycles in the state.
- IDLE: all enables are 0. The state moves to PFC_START when sw_state_i=1 and fault_i=0. While sw_state_i=0, retry_cnt clears.
- PFC_START: pfc_en_o=0.
  - sw_state_i=0 → IDLE.
  - After PFC_DLY cycles → PFC_WAIT.
- PFC_WAIT: pfc_en_o=1.
  - pfc_ok_i=1 → DCDC_START.
  - Otherwise, sw_state_i=0 → SHUTDOWN.
  - Otherwise, after PFC_TMO cycles → FAULT.
  - If pfc_ok_i and the timeout occur in the same cycle, pfc_ok_i wins.
- DCDC_START: pfc_en_o=1.
  - pfc_ok_i=0 → FAULT.
  - sw_state_i=0 → SHUTDOWN.
  - After DCDC_DLY cycles → RUN.
- RUN: pfc_en_o=1, dcdc_en_o=1, run_o=1.
  - pfc_ok_i=0 → FAULT.
  - sw_state_i=0 → SHUTDOWN.
- SHUTDOWN: dcdc_en_o=0, pfc_en_o=1. After OFF_DLY cycles → IDLE. sw_state_i is ignored until IDLE.
- FAULT: all enables are 0.
  - On entry, retry_cnt increments, saturating at RETRY_MAX.
  - If the incremented value equals RETRY_MAX, the state goes directly to LOCKOUT instead of FAULT.
  - Otherwise the state exits to IDLE once RETRY_WAIT cycles have elapsed and fault_i=0. If fault_i is still 1, the state holds in FAULT.
- LOCKOUT: all enables are 0, lockout_o=1. Exit to IDLE requires sw_state_i=0 and fault_i=0; retry_cnt clears on that exit.
- Priority within a cycle: fault_i=1 in states 0–5 → FAULT. This overrides everything, including sw_state_i=0 and a counter expiring in the same cycle.
- retry_cnt is 3 bits. It clears only on reset, in IDLE with sw_state_i=0, or on LOCKOUT exit. Reaching RUN does not clear it.

## Timing
- Reset values: state IDLE, all outputs 0, state_o=0, counter 0, retry_cnt 0.
- Reset applied mid-operation forces all of the above on the next edge. dcdc_en_o and pfc_en_o drop on that same edge.
- All outputs are registers loaded from the next-state decode, so they change on the same edge as the state register. There are no combinational paths from input to output.
- Input-to-output latency is 1 clock: an input sampled at edge k is reflected in the outputs after edge k.
- pfc_en_o rises PFC_DLY edges after the edge that samples sw_state_i=1 in IDLE.
- dcdc_en_o rises DCDC_DLY edges after the edge that samples pfc_ok_i=1 in PFC_WAIT.
- On shutdown, dcdc_en_o falls 1 edge after sw_state_i=0 is sampled. pfc_en_o falls OFF_DLY edges after dcdc_en_o falls.
- dcdc_en_o=1 always implies pfc_en_o=1.

## Test plan
Bench parameters: PFC_DLY=4, PFC_TMO=20, DCDC_DLY=8, OFF_DLY=5, RETRY_WAIT=10, RETRY_MAX=3.

1. Normal start: sw_state_i=1 sampled at edge 0; pfc_ok_i=1 from edge 10 → pfc_en_o high after edge 4, dcdc_en_o and run_o high after edge 18, state_o=4.
2. Normal stop: in RUN, sw_state_i=0 sampled at edge T → dcdc_en_o and run_o low after T, pfc_en_o low after T+5, state_o=0.
3. Bus timeout: pfc_ok_i held 0 → pfc_en_o high edges 4–24, FAULT after edge 24 with pfc_en_o=0, restart to PFC_START 11 edges later (10-cycle FAULT wait, then IDLE).
4. Lockout: three consecutive timeouts → lockout_o=1 and state_o=7 on the third fault; this holds with sw_state_i=1. Then sw_state_i=0 → IDLE, lockout_o=0. A new sw_state_i=1 gives a normal start as in scenario 1.
5. Simultaneous events:
   - In RUN, fault_i=1 and sw_state_i=0 at the same edge → FAULT (state_o=6), both enables 0 after that edge, no SHUTDOWN.
   - In PFC_WAIT, pfc_ok_i rises on the timeout cycle → DCDC_START.
6. Reset mid-RUN: rst_i=1 for one cycle → all outputs 0 after that edge, state_o=0, retry_cnt=0. A subsequent sw_state_i=1 restarts as in scenario 1.
